adc_acq_ctrl: RTL and testbench

ADC_ACQ_CTRL -- requirements
Module: adc_acq_ctrl

---
 rtl/adc_acq_pkg.sv | 38 +++
 rtl/adc_tick_gen.sv | 34 +++
 rtl/adc_acq_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_adc_acq_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acq_pkg.sv
// Shared state encoding, default timing constants and width helpers for the
// ADC acquisition controller and its sample-tick divider.
package adc_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWRUP     = 3'd1,
        ST_WAIT_TICK = 3'd2,
        ST_SAMPLE    = 3'd3,
        ST_CONVERT   = 3'd4,
        ST_READ      = 3'd5,
        ST_PUSH      = 3'd6,
        ST_DONE      = 3'd7
    } acq_state_e;

    localparam int unsigned DEF_FRAME_LEN    = 32'd512;
    localparam int unsigned DEF_SAMPLE_DIV   = 32'd2000;
    localparam int unsigned DEF_PWRUP_CYCLES = 32'd20;
    localparam int unsigned DEF_SH_CYCLES    = 32'd4;
    localparam int unsigned DEF_RD_CYCLES    = 32'd3;
    localparam int unsigned DEF_EOC_TIMEOUT  = 32'd200;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 while enabled, parks at zero
// while disabled, and flags the terminal count as the sample tick.
module adc_tick_gen
    import adc_acq_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned TW = width_of(SAMPLE_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 32'd1);

    logic [TW-1:0] tick_cnt_r;

    // Divider counter; restarting from zero on enable keeps the first tick a full period out.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (!enable) begin
            tick_cnt_r <= '0;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
        end
    end

    assign tick = enable && (tick_cnt_r == TICK_LAST);

endmodule

// File: rtl/adc_acq_ctrl.sv
// ADC acquisition controller: powers up a parallel ADC, samples on a fixed tick,
// reads each conversion and streams FRAME_LEN bytes to a ready/valid consumer.
module adc_acq_ctrl
    import adc_acq_pkg::*;
#(
    parameter int unsigned FRAME_LEN    = DEF_FRAME_LEN,
    parameter int unsigned SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int unsigned PWRUP_CYCLES = DEF_PWRUP_CYCLES,
    parameter int unsigned SH_CYCLES    = DEF_SH_CYCLES,
    parameter int unsigned RD_CYCLES    = DEF_RD_CYCLES,
    parameter int unsigned EOC_TIMEOUT  = DEF_EOC_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] AD,
    input  logic       EOC_n,
    output logic       PD,
    output logic       CS_RD_n,
    output logic       AD_CLK,
    output logic       S_H,
    output logic [7:0] smp_data,
    output logic       smp_valid,
    input  logic       smp_ready,
    output logic       smp_last,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 32'd1);
    localparam int unsigned PH_W  = width_of(max4(PWRUP_CYCLES, SH_CYCLES, RD_CYCLES, EOC_TIMEOUT));

    localparam logic [PH_W-1:0]  PWRUP_LAST = PH_W'(PWRUP_CYCLES - 32'd1);
    localparam logic [PH_W-1:0]  SH_LAST    = PH_W'(SH_CYCLES - 32'd1);
    localparam logic [PH_W-1:0]  RD_LAST    = PH_W'(RD_CYCLES - 32'd1);
    localparam logic [PH_W-1:0]  EOC_LAST   = PH_W'(EOC_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_LEN - 32'd1);

    acq_state_e       state_r, state_s;
    logic [PH_W-1:0]  phase_cnt_r, phase_cnt_s;
    logic [CNT_W-1:0] sample_cnt_r, sample_cnt_s, cnt_inc_s;
    logic [1:0]       eoc_sync_r;
    logic             tick_en_s, tick_s, capture_s;
    logic             overrun_r, overrun_s, timeout_err_r, timeout_s;
    logic             pd_r, pd_s, cs_rd_n_r, cs_rd_n_s, s_h_r, s_h_s, ad_clk_r;
    logic             valid_r, valid_s, last_r, last_s, busy_r, busy_s, done_r, done_s;
    logic [7:0]       smp_data_r;

    // The tick runs only once power-up has settled and until the frame returns to idle.
    assign tick_en_s = (state_r != ST_IDLE) && (state_r != ST_PWRUP);

    adc_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (tick_en_s),
        .tick   (tick_s)
    );

    // Two-flop synchronizer for the asynchronous end-of-conversion strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            eoc_sync_r <= 2'b11;
        end else begin
            eoc_sync_r <= {eoc_sync_r[0], EOC_n};
        end
    end

    assign cnt_inc_s = sample_cnt_r + 1'b1;

    // Next-state, phase timing, sample count and sticky error flags.
    always_comb begin
        state_s      = state_r;
        phase_cnt_s  = phase_cnt_r + 1'b1;
        sample_cnt_s = sample_cnt_r;
        timeout_s    = timeout_err_r;
        capture_s    = 1'b0;
        if (tick_s && (state_r != ST_WAIT_TICK)) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end

        case (state_r)
            ST_IDLE: begin
                phase_cnt_s = '0;
                if (start && !abort) begin
                    state_s      = ST_PWRUP;
                    overrun_s    = 1'b0;
                    timeout_s    = 1'b0;
                    sample_cnt_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PWRUP: begin
                if (phase_cnt_r == PWRUP_LAST) begin
                    state_s     = ST_WAIT_TICK;
                    phase_cnt_s = '0;
                end else begin
                    state_s = ST_PWRUP;
                end
            end
            ST_WAIT_TICK: begin
                phase_cnt_s = '0;
                if (tick_s) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_WAIT_TICK;
                end
            end
            ST_SAMPLE: begin
                if (phase_cnt_r == SH_LAST) begin
                    state_s     = ST_CONVERT;
                    phase_cnt_s = '0;
                end else begin
                    state_s = ST_SAMPLE;
                end
            end
            ST_CONVERT: begin
                if (!eoc_sync_r[1]) begin
                    state_s     = ST_READ;
                    phase_cnt_s = '0;
                end else if (phase_cnt_r == EOC_LAST) begin
                    state_s     = ST_DONE;
                    phase_cnt_s = '0;
                    timeout_s   = 1'b1;
                end else begin
                    state_s = ST_CONVERT;
                end
            end
            ST_READ: begin
                if (phase_cnt_r == RD_LAST) begin
                    state_s     = ST_PUSH;
                    phase_cnt_s = '0;
                    capture_s   = 1'b1;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_PUSH: begin
                phase_cnt_s = '0;
                if (smp_ready) begin
                    sample_cnt_s = cnt_inc_s;
                    if (cnt_inc_s == CNT_FULL) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WAIT_TICK;
                    end
                end else begin
                    state_s = ST_PUSH;
                end
            end
            ST_DONE: begin
                phase_cnt_s = '0;
                state_s     = ST_IDLE;
            end
            default: begin
                phase_cnt_s = '0;
                state_s     = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_s     = ST_IDLE;
            phase_cnt_s = '0;
        end else begin
            state_s = state_s;
        end
    end

    // Output decode from the next state so every pin comes straight from a flop.
    always_comb begin
        pd_s      = (state_s == ST_IDLE) || (state_s == ST_DONE);
        s_h_s     = (state_s == ST_SAMPLE);
        cs_rd_n_s = (state_s != ST_READ);
        valid_s   = (state_s == ST_PUSH);
        last_s    = valid_s && (sample_cnt_s == CNT_LAST);
        busy_s    = (state_s != ST_IDLE);
        done_s    = (state_s == ST_DONE);
    end

    // State, counters, flags and registered pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            phase_cnt_r   <= '0;
            sample_cnt_r  <= '0;
            overrun_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            pd_r          <= 1'b1;
            cs_rd_n_r     <= 1'b1;
            s_h_r         <= 1'b0;
            ad_clk_r      <= 1'b0;
            valid_r       <= 1'b0;
            last_r        <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            smp_data_r    <= 8'h00;
        end else begin
            state_r       <= state_s;
            phase_cnt_r   <= phase_cnt_s;
            sample_cnt_r  <= sample_cnt_s;
            overrun_r     <= overrun_s;
            timeout_err_r <= timeout_s;
            pd_r          <= pd_s;
            cs_rd_n_r     <= cs_rd_n_s;
            s_h_r         <= s_h_s;
            ad_clk_r      <= pd_s ? 1'b0 : ~ad_clk_r;
            valid_r       <= valid_s;
            last_r        <= last_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            smp_data_r    <= capture_s ? AD : smp_data_r;
        end
    end

    assign PD          = pd_r;
    assign CS_RD_n     = cs_rd_n_r;
    assign S_H         = s_h_r;
    assign AD_CLK      = ad_clk_r;
    assign smp_data    = smp_data_r;
    assign smp_valid   = valid_r;
    assign smp_last    = last_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign overrun     = overrun_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Directed frames with randomized ADC data and EOC latency, checked against an
// ADC/timing model and per-frame expectations derived from the frame rules.
module tb_adc_acq_ctrl;

    localparam int FL  = 4;
    localparam int DIV = 2000;
    localparam int PWR = 20;
    localparam int SH  = 4;
    localparam int RD  = 3;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst, start, abort, smp_ready;
    logic [7:0] AD = 8'h00;
    logic       EOC_n = 1'b1;
    logic       PD, CS_RD_n, AD_CLK, S_H, smp_valid, smp_last, busy, done, overrun, timeout_err;
    logic [7:0] smp_data;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;

    adc_acq_ctrl #(
        .FRAME_LEN(FL), .SAMPLE_DIV(DIV), .PWRUP_CYCLES(PWR),
        .SH_CYCLES(SH), .RD_CYCLES(RD), .EOC_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .AD(AD), .EOC_n(EOC_n),
        .PD(PD), .CS_RD_n(CS_RD_n), .AD_CLK(AD_CLK), .S_H(S_H),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_last(smp_last),
        .busy(busy), .done(done), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: new data per sample strobe, EOC after a delay, EOC released once read starts.
    bit         eoc_never = 1'b0, eoc_rand = 1'b0, a5_mode = 1'b0;
    bit         a5_used = 1'b0, adc_sh_prev = 1'b0, adc_cs_prev = 1'b1;
    int         eoc_cd = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (busy !== 1'b1) begin
            EOC_n = 1'b1;
            eoc_cd = 0;
            a5_used = 1'b0;
        end else begin
            if (S_H === 1'b1 && !adc_sh_prev) begin
                if (a5_mode && !a5_used) begin
                    AD = 8'hA5;
                    a5_used = 1'b1;
                end else begin
                    AD = 8'($urandom_range(1, 255));
                end
            end
            if (adc_sh_prev && S_H === 1'b0 && !eoc_never) begin
                eoc_cd = eoc_rand ? int'($urandom_range(1, 40)) : 10;
            end else if (eoc_cd > 0) begin
                eoc_cd--;
                if (eoc_cd == 0) EOC_n = 1'b0;
            end
            if (CS_RD_n === 1'b0) EOC_n = 1'b1;
            if (CS_RD_n === 1'b0 && adc_cs_prev) exp_q.push_back(AD);
        end
        adc_sh_prev = (S_H === 1'b1);
        adc_cs_prev = (CS_RD_n !== 1'b0);
    end

    // Output monitor: pulse widths, tick times, transfers, done pulses, AD_CLK behaviour.
    int         sh_rise_q[$], sh_w_q[$], cs_w_q[$];
    logic [7:0] xd_q[$];
    logic       xl_q[$];
    int         sh_run = 0, cs_run = 0, done_n = 0, done_cyc = 0, done_wide = 0;
    int         stab_err = 0, adclk_err = 0;
    bit         sh_prev = 0, cs_low_prev = 0, done_prev = 0, valid_prev = 0, xfer_prev = 0;
    bit         pd_low_prev = 0;
    logic       adclk_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always @(negedge clk) begin
        if (S_H === 1'b1) begin
            if (!sh_prev) sh_rise_q.push_back(cyc);
            sh_run++;
        end else if (sh_prev) begin
            sh_w_q.push_back(sh_run);
            sh_run = 0;
        end
        if (CS_RD_n === 1'b0) cs_run++;
        else if (cs_low_prev) begin
            cs_w_q.push_back(cs_run);
            cs_run = 0;
        end
        if (smp_valid === 1'b1 && smp_ready === 1'b1) begin
            xd_q.push_back(smp_data);
            xl_q.push_back(smp_last);
        end
        if (done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
            if (done_prev) done_wide++;
        end
        if (valid_prev && !xfer_prev && smp_valid === 1'b1 && smp_data !== data_prev) stab_err++;
        if (PD === 1'b1 && AD_CLK !== 1'b0) adclk_err++;
        if (PD === 1'b0 && pd_low_prev && AD_CLK === adclk_prev) adclk_err++;
        if (PD === 1'b0 && !pd_low_prev && AD_CLK !== 1'b1) adclk_err++;
        sh_prev     = (S_H === 1'b1);
        cs_low_prev = (CS_RD_n === 1'b0);
        done_prev   = (done === 1'b1);
        valid_prev  = (smp_valid === 1'b1);
        xfer_prev   = (smp_valid === 1'b1 && smp_ready === 1'b1);
        pd_low_prev = (PD === 1'b0);
        adclk_prev  = AD_CLK;
        data_prev   = smp_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int start_cyc;
    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        int k = 0;
        while (done_n == base && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 32'(done_n != base), 32'd1);
        step(3);
    endtask

    task automatic wait_sig_valid(input int budget, input string tag);
        int k = 0;
        while (smp_valid !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 32'(smp_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pd"}, 32'(PD), 32'd1);
        chk({tag, "_cs"}, 32'(CS_RD_n), 32'd1);
        chk({tag, "_sh"}, 32'(S_H), 32'd0);
        chk({tag, "_adclk"}, 32'(AD_CLK), 32'd0);
        chk({tag, "_data"}, 32'(smp_data), 32'd0);
        chk({tag, "_valid"}, 32'(smp_valid), 32'd0);
        chk({tag, "_last"}, 32'(smp_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
        chk({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    endtask

    // Transfers of one frame must match the ADC values in order, last flag on the final one.
    task automatic check_frame(input string tag, input int xb, input int eb);
        chk({tag, "_xfers"}, 32'(xd_q.size() - xb), 32'(FL));
        for (int i = 0; i < FL; i++) begin
            if (xb + i < xd_q.size() && eb + i < exp_q.size()) begin
                chk($sformatf("%s_data%0d", tag, i), 32'(xd_q[xb + i]), 32'(exp_q[eb + i]));
                chk($sformatf("%s_last%0d", tag, i), 32'(xl_q[xb + i]), 32'(i == FL - 1));
            end
        end
    endtask

    int xb, eb, sb, wb, cb, d0, dw0, ae0, se0, k;
    logic [7:0] held;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; smp_ready = 1'b1;
        step(3);
        check_reset_outputs("rst0");
        rst = 1'b0;
        step(2);

        // Frame 1: nominal timing, first sample forced to 8'hA5.
        a5_mode = 1'b1; smp_ready = 1'b1;
        xb = xd_q.size(); eb = exp_q.size(); sb = sh_rise_q.size(); wb = sh_w_q.size();
        cb = cs_w_q.size(); d0 = done_n; dw0 = done_wide; ae0 = adclk_err;
        do_start();
        chk("f1_pd_low", 32'(PD), 32'd0);
        chk("f1_busy", 32'(busy), 32'd1);
        wait_done(d0, PWR + DIV * (FL + 1), "f1_done_seen");
        a5_mode = 1'b0;
        chk("f1_rises", 32'(sh_rise_q.size() - sb), 32'(FL));
        if (sh_rise_q.size() >= sb + FL) begin
            chk("f1_first_tick", 32'(sh_rise_q[sb] - start_cyc), 32'(PWR + DIV));
            for (int i = 1; i < FL; i++)
                chk($sformatf("f1_tick_gap%0d", i), 32'(sh_rise_q[sb + i] - sh_rise_q[sb + i - 1]), 32'(DIV));
        end
        for (int i = 0; i < FL; i++) begin
            if (wb + i < sh_w_q.size()) chk($sformatf("f1_sh_w%0d", i), 32'(sh_w_q[wb + i]), 32'(SH));
            if (cb + i < cs_w_q.size()) chk($sformatf("f1_cs_w%0d", i), 32'(cs_w_q[cb + i]), 32'(RD));
        end
        check_frame("f1", xb, eb);
        if (xd_q.size() > xb) chk("f1_a5", 32'(xd_q[xb]), 32'h0000_00A5);
        chk("f1_done_cnt", 32'(done_n - d0), 32'd1);
        chk("f1_done_wide", 32'(done_wide - dw0), 32'd0);
        chk("f1_pd_after", 32'(PD), 32'd1);
        chk("f1_busy_after", 32'(busy), 32'd0);
        chk("f1_ovr", 32'(overrun), 32'd0);
        chk("f1_tmo", 32'(timeout_err), 32'd0);
        chk("f1_adclk", 32'(adclk_err - ae0), 32'd0);

        // Frame 2: consumer stalls 2500 cycles on the first sample.
        smp_ready = 1'b0;
        xb = xd_q.size(); eb = exp_q.size(); sb = sh_rise_q.size(); d0 = done_n; se0 = stab_err;
        do_start();
        wait_sig_valid(PWR + DIV + 500, "f2_valid_seen");
        held = smp_data;
        step(2500);
        chk("f2_overrun", 32'(overrun), 32'd1);
        chk("f2_hold", 32'(smp_data), 32'(held));
        if (exp_q.size() > eb) chk("f2_hold_exp", 32'(held), 32'(exp_q[eb]));
        smp_ready = 1'b1;
        wait_done(d0, DIV * (FL + 3), "f2_done_seen");
        chk("f2_stable", 32'(stab_err - se0), 32'd0);
        check_frame("f2", xb, eb);
        if (sh_rise_q.size() > sb + 1)
            chk("f2_dropped_tick", 32'(sh_rise_q[sb + 1] - sh_rise_q[sb]), 32'(2 * DIV));
        chk("f2_done_cnt", 32'(done_n - d0), 32'd1);
        chk("f2_ovr_sticky", 32'(overrun), 32'd1);

        // Frame 3: EOC never arrives.
        eoc_never = 1'b1;
        xb = xd_q.size(); sb = sh_rise_q.size(); d0 = done_n;
        do_start();
        chk("f3_ovr_cleared", 32'(overrun), 32'd0);
        wait_done(d0, PWR + DIV + TMO + 100, "f3_done_seen");
        eoc_never = 1'b0;
        chk("f3_tmo", 32'(timeout_err), 32'd1);
        if (sh_rise_q.size() > sb) chk("f3_tmo_time", 32'(done_cyc - sh_rise_q[sb]), 32'(SH + TMO));
        chk("f3_xfers", 32'(xd_q.size() - xb), 32'd0);
        chk("f3_done_cnt", 32'(done_n - d0), 32'd1);
        chk("f3_busy_after", 32'(busy), 32'd0);
        chk("f3_pd_after", 32'(PD), 32'd1);

        // Frame 4: abort while reading.
        d0 = done_n;
        do_start();
        chk("f4_tmo_cleared", 32'(timeout_err), 32'd0);
        k = 0;
        while (CS_RD_n !== 1'b0 && k < PWR + DIV + 100) begin
            step(1);
            k++;
        end
        chk("f4_read_seen", 32'(CS_RD_n), 32'd0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("f4_busy", 32'(busy), 32'd0);
        chk("f4_pd", 32'(PD), 32'd1);
        chk("f4_sh", 32'(S_H), 32'd0);
        chk("f4_cs", 32'(CS_RD_n), 32'd1);
        chk("f4_valid", 32'(smp_valid), 32'd0);
        step(5);
        chk("f4_no_done", 32'(done_n - d0), 32'd0);

        // Frame 5: fresh frame after abort, random EOC latency.
        eoc_rand = 1'b1;
        xb = xd_q.size(); eb = exp_q.size(); sb = sh_rise_q.size(); d0 = done_n;
        do_start();
        wait_done(d0, PWR + DIV * (FL + 1), "f5_done_seen");
        eoc_rand = 1'b0;
        check_frame("f5", xb, eb);
        if (sh_rise_q.size() >= sb + FL)
            chk("f5_tick_gap", 32'(sh_rise_q[sb + FL - 1] - sh_rise_q[sb]), 32'(DIV * (FL - 1)));
        chk("f5_done_cnt", 32'(done_n - d0), 32'd1);

        // Abort and start together: abort wins.
        start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        step(3);
        chk("sa_busy_later", 32'(busy), 32'd0);
        chk("sa_pd", 32'(PD), 32'd1);

        // Frame 6: reset while a sample waits in PUSH with overrun already set.
        smp_ready = 1'b0;
        do_start();
        wait_sig_valid(PWR + DIV + 500, "f6_valid_seen");
        step(DIV + 100);
        chk("f6_pre_ovr", 32'(overrun), 32'd1);
        chk("f6_pre_valid", 32'(smp_valid), 32'd1);
        rst = 1'b1;
        step(1);
        check_reset_outputs("f6_rst");
        rst = 1'b0;
        smp_ready = 1'b1;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
